// File: rtl/cbud_mod_counter.sv
// cbud_mod_counter: parametrised modulo up/down counter with parallel load,
// synchronous preset, cascade carry in/out and a sticky out-of-range load flag.
// Optional feature macro: CBUD_WRAP_CNT_EN adds the saturating 8-bit wrap
// counter output wraps_o.
module cbud_mod_counter #(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic             clk_i,
  input  logic             cs_i,
  input  logic             sd_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             en_i,
  input  logic             cai_i,
  input  logic             up_i,
`ifdef CBUD_WRAP_CNT_EN
  output logic [7:0]       wraps_o,
`endif
  output logic [WIDTH-1:0] q_o,
  output logic             cao_o,
  output logic             err_o
);

  localparam longint unsigned FULL_RANGE = 64'd1 << WIDTH;
  localparam logic [WIDTH-1:0] TOP       = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] ZERO      = '0;

  // Reject illegal parameter combinations at elaboration
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("cbud_mod_counter: WIDTH must be 2..32");
  end
  if (MODULUS < 64'd2 || MODULUS > FULL_RANGE) begin : g_bad_modulus
    $error("cbud_mod_counter: MODULUS must be 2..2**WIDTH");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic             err_q, err_d;
  logic             over_c;
  logic             at_top_c;
  logic             at_zero_c;
  logic             step_c;

  // Out-of-range load detection; impossible when the modulus covers every code
  if (MODULUS == FULL_RANGE) begin : g_full
    assign over_c = 1'b0;
  end else begin : g_partial
    assign over_c = (d_i > TOP);
  end

  assign at_top_c  = (q_q == TOP);
  assign at_zero_c = (q_q == ZERO);
  assign step_c    = en_i & cai_i;

  // Cascade carry/borrow out from the current value, deliberately ungated by controls
  assign cao_o = step_c & (up_i ? at_top_c : at_zero_c);

  // Next-state for value and error flag: preset > load > count > hold
  always_comb begin
    q_d   = q_q;
    err_d = err_q;
    if (sd_i) begin
      q_d = TOP;
    end else if (ld_i) begin
      if (over_c) begin
        q_d   = TOP;
        err_d = 1'b1;
      end else begin
        q_d = d_i;
      end
    end else if (step_c) begin
      if (up_i) begin
        q_d = at_top_c ? ZERO : q_q + WIDTH'(1);
      end else begin
        q_d = at_zero_c ? TOP : q_q - WIDTH'(1);
      end
    end
  end

  // State register with synchronous clear
  always_ff @(posedge clk_i) begin
    if (cs_i) begin
      q_q   <= ZERO;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      err_q <= err_d;
    end
  end

  assign q_o   = q_q;
  assign err_o = err_q;

`ifdef CBUD_WRAP_CNT_EN
  logic [7:0] wraps_q, wraps_d;
  logic       wrap_c;

  // A wrap is a counting step taken from the terminal value
  assign wrap_c = cao_o & ~sd_i & ~ld_i;

  // Saturating wrap event counter
  always_comb begin
    wraps_d = wraps_q;
    if (wrap_c && (wraps_q != 8'hFF)) begin
      wraps_d = wraps_q + 8'd1;
    end
  end

  // Wrap counter register, cleared only by the synchronous clear
  always_ff @(posedge clk_i) begin
    if (cs_i) begin
      wraps_q <= 8'd0;
    end else begin
      wraps_q <= wraps_d;
    end
  end

  assign wraps_o = wraps_q;
`endif

endmodule

// File: tb/tb_cbud_mod_counter.sv
// Self-checking bench for cbud_mod_counter: table-driven single-stage vectors
// with a scoreboard queue, plus hand-written cascade and 8-bit sequences.
module tb_cbud_mod_counter;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  // Stage A: WIDTH=4, MODULUS=10
  logic       a_cs, a_sd, a_ld, a_en, a_cai, a_up;
  logic [3:0] a_d, a_q;
  logic       a_cao, a_err;
  logic [7:0] a_wraps;

  cbud_mod_counter #(.WIDTH(4), .MODULUS(10)) u_a (
    .clk_i(clk), .cs_i(a_cs), .sd_i(a_sd), .ld_i(a_ld), .d_i(a_d),
    .en_i(a_en), .cai_i(a_cai), .up_i(a_up),
`ifdef CBUD_WRAP_CNT_EN
    .wraps_o(a_wraps),
`endif
    .q_o(a_q), .cao_o(a_cao), .err_o(a_err)
  );
`ifndef CBUD_WRAP_CNT_EN
  assign a_wraps = 8'd0;
`endif

  // Two-digit BCD cascade
  logic       c_cs;
  logic [3:0] lo_q, hi_q;
  logic       lo_cao, hi_cao, lo_err, hi_err;
  logic [7:0] lo_wraps, hi_wraps;

  cbud_mod_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .clk_i(clk), .cs_i(c_cs), .sd_i(1'b0), .ld_i(1'b0), .d_i(4'd0),
    .en_i(1'b1), .cai_i(1'b1), .up_i(1'b1),
`ifdef CBUD_WRAP_CNT_EN
    .wraps_o(lo_wraps),
`endif
    .q_o(lo_q), .cao_o(lo_cao), .err_o(lo_err)
  );

  cbud_mod_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .clk_i(clk), .cs_i(c_cs), .sd_i(1'b0), .ld_i(1'b0), .d_i(4'd0),
    .en_i(1'b1), .cai_i(lo_cao), .up_i(1'b1),
`ifdef CBUD_WRAP_CNT_EN
    .wraps_o(hi_wraps),
`endif
    .q_o(hi_q), .cao_o(hi_cao), .err_o(hi_err)
  );
`ifndef CBUD_WRAP_CNT_EN
  assign lo_wraps = 8'd0;
  assign hi_wraps = 8'd0;
`endif

  // Stage W: WIDTH=8, default modulus
  logic       w_cs, w_ld, w_en, w_cai, w_up;
  logic [7:0] w_d, w_q;
  logic       w_cao, w_err;
  logic [7:0] w_wraps;

  cbud_mod_counter #(.WIDTH(8)) u_w (
    .clk_i(clk), .cs_i(w_cs), .sd_i(1'b0), .ld_i(w_ld), .d_i(w_d),
    .en_i(w_en), .cai_i(w_cai), .up_i(w_up),
`ifdef CBUD_WRAP_CNT_EN
    .wraps_o(w_wraps),
`endif
    .q_o(w_q), .cao_o(w_cao), .err_o(w_err)
  );
`ifndef CBUD_WRAP_CNT_EN
  assign w_wraps = 8'd0;
`endif

  typedef struct {
    logic       cs, sd, ld;
    logic [3:0] d;
    logic       en, cai, up;
    logic [3:0] q;
    logic       err;
    logic       cao;
    logic [7:0] wraps;
  } vec_t;

  typedef struct {
    logic [3:0] q;
    logic       err;
    logic [7:0] wraps;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic void add(input logic cs, sd, ld, input logic [3:0] d,
                              input logic en, cai, up, input logic [3:0] q,
                              input logic err, cao, input logic [7:0] wraps);
    vec_t v;
    v.cs = cs; v.sd = sd; v.ld = ld; v.d = d;
    v.en = en; v.cai = cai; v.up = up;
    v.q = q; v.err = err; v.cao = cao; v.wraps = wraps;
    vecs.push_back(v);
  endfunction

  task automatic w_step(input logic cs, ld, input logic [7:0] d, input logic en, cai, up);
    @(negedge clk);
    w_cs = cs; w_ld = ld; w_d = d; w_en = en; w_cai = cai; w_up = up;
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    exp_t got;
    logic [3:0] ones, tens;

    a_cs = 1'b0; a_sd = 1'b0; a_ld = 1'b0; a_d = 4'd0;
    a_en = 1'b0; a_cai = 1'b0; a_up = 1'b1;
    c_cs = 1'b1;
    w_cs = 1'b0; w_ld = 1'b0; w_d = 8'd0; w_en = 1'b0; w_cai = 1'b0; w_up = 1'b1;

    // cs sd ld d  en cai up  q err cao wraps  (cao is for the current Q)
    add(1, 0, 0, 4'd0, 0, 0, 1, 4'd0, 0, 0, 8'd0);
    for (int i = 0; i < 12; i++)
      add(0, 0, 0, 4'd0, 1, 1, 1, 4'((i + 1) % 10), 0, (i == 9), (i >= 9) ? 8'd1 : 8'd0);
    add(1, 0, 0, 4'd0, 1, 1, 0, 4'd0, 0, 0, 8'd0);
    add(0, 0, 0, 4'd0, 1, 1, 0, 4'd9, 0, 1, 8'd1);
    add(0, 0, 0, 4'd0, 1, 1, 0, 4'd8, 0, 0, 8'd1);
    add(0, 0, 0, 4'd0, 1, 1, 0, 4'd7, 0, 0, 8'd1);
    add(0, 0, 0, 4'd0, 1, 1, 1, 4'd8, 0, 0, 8'd1);
    add(0, 0, 1, 4'd12, 0, 1, 1, 4'd9, 1, 0, 8'd1);
    add(0, 0, 1, 4'd3, 0, 1, 1, 4'd3, 1, 0, 8'd1);
    add(0, 0, 0, 4'd0, 1, 1, 1, 4'd4, 1, 0, 8'd1);
    add(1, 0, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 8'd0);
    add(1, 1, 1, 4'd5, 1, 1, 1, 4'd0, 0, 0, 8'd0);
    add(0, 1, 1, 4'd12, 0, 0, 1, 4'd9, 0, 0, 8'd0);
    add(0, 0, 1, 4'd9, 1, 1, 1, 4'd9, 0, 1, 8'd0);
    add(0, 0, 0, 4'd0, 0, 1, 1, 4'd9, 0, 0, 8'd0);
    add(0, 0, 0, 4'd0, 1, 0, 1, 4'd9, 0, 0, 8'd0);
    add(0, 0, 1, 4'd15, 0, 0, 1, 4'd9, 1, 0, 8'd0);
    add(0, 0, 1, 4'd0, 0, 0, 1, 4'd0, 1, 0, 8'd0);
    add(0, 1, 0, 4'd0, 0, 0, 1, 4'd9, 1, 0, 8'd0);
    add(0, 0, 0, 4'd0, 1, 1, 1, 4'd0, 1, 1, 8'd1);
    add(0, 0, 0, 4'd0, 1, 1, 0, 4'd9, 1, 1, 8'd2);

    foreach (vecs[i]) begin
      @(negedge clk);
      a_cs = vecs[i].cs; a_sd = vecs[i].sd; a_ld = vecs[i].ld; a_d = vecs[i].d;
      a_en = vecs[i].en; a_cai = vecs[i].cai; a_up = vecs[i].up;
      #1;
      check($sformatf("vec%0d_cao", i), 32'(a_cao), 32'(vecs[i].cao));
      e.q = vecs[i].q; e.err = vecs[i].err; e.wraps = vecs[i].wraps;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      check($sformatf("vec%0d_q", i), 32'(a_q), 32'(got.q));
      check($sformatf("vec%0d_err", i), 32'(a_err), 32'(got.err));
`ifdef CBUD_WRAP_CNT_EN
      check($sformatf("vec%0d_wraps", i), 32'(a_wraps), 32'(got.wraps));
`endif
    end

    // Long run: 300 wraps of the mod-10 stage, wrap counter saturates
    @(negedge clk);
    a_cs = 1'b1; a_sd = 1'b0; a_ld = 1'b0; a_en = 1'b1; a_cai = 1'b1; a_up = 1'b1;
    @(negedge clk);
    a_cs = 1'b0;
    repeat (3000) @(posedge clk);
    #1;
    check("long_q", 32'(a_q), 32'd0);
`ifdef CBUD_WRAP_CNT_EN
    check("long_wraps_sat", 32'(a_wraps), 32'd255);
`endif

    // Cascade: two BCD digits, 100 clocks from 00
    @(negedge clk);
    c_cs = 1'b1;
    @(posedge clk);
    #1;
    check("casc_rst_lo", 32'(lo_q), 32'd0);
    check("casc_rst_hi", 32'(hi_q), 32'd0);
    @(negedge clk);
    c_cs = 1'b0;
    ones = 4'd0;
    tens = 4'd0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (ones == 4'd9) begin
        ones = 4'd0;
        tens = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
      end else begin
        ones = ones + 4'd1;
      end
      check($sformatf("casc%0d_lo", i), 32'(lo_q), 32'(ones));
      check($sformatf("casc%0d_hi", i), 32'(hi_q), 32'(tens));
    end
    check("casc_end", 32'({hi_q, lo_q}), 32'h00);

    // 8-bit full-range stage
    w_step(1, 0, 8'd0, 0, 0, 1);
    check("w_rst_q", 32'(w_q), 32'd0);
    check("w_rst_cao", 32'(w_cao), 32'd0);
    w_step(0, 1, 8'd255, 0, 0, 1);
    check("w_ld255_q", 32'(w_q), 32'd255);
    check("w_ld255_err", 32'(w_err), 32'd0);
    w_step(0, 1, 8'd254, 0, 0, 1);
    check("w_ld254_q", 32'(w_q), 32'd254);
    for (int i = 0; i < 3; i++) begin
      w_step(0, 0, 8'd0, 1, 0, 1);
      check($sformatf("w_hold%0d", i), 32'(w_q), 32'd254);
      check($sformatf("w_hold%0d_cao", i), 32'(w_cao), 32'd0);
    end
    w_step(0, 0, 8'd0, 1, 1, 1);
    check("w_up_255", 32'(w_q), 32'd255);
    check("w_cao_top", 32'(w_cao), 32'd1);
    w_step(0, 0, 8'd0, 1, 1, 1);
    check("w_wrap_q", 32'(w_q), 32'd0);
    check("w_cao_zero_up", 32'(w_cao), 32'd0);
    @(negedge clk);
    w_up = 1'b0;
    #1;
    check("w_cao_zero_dn", 32'(w_cao), 32'd1);
    @(posedge clk);
    #1;
    check("w_dn_wrap_q", 32'(w_q), 32'd255);
    check("w_err_final", 32'(w_err), 32'd0);
`ifdef CBUD_WRAP_CNT_EN
    check("w_wraps", 32'(w_wraps), 32'd2);
`endif

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
